// File: rtl/nabp_filtered_ram_swap_ctrl.sv
// -----------------------------------------------------------------------------
// nabp_filtered_ram_swap_ctrl
//
// Ping-pong scheduler for the two filtered RAM swappables. The host fills one
// bank with projection line k+1 while the processing pair back-projects line
// k from the other bank. The block owns angle sequencing for one run of
// NUM_ANGLES lines, which are processed strictly in angle order.
//
// Kick/done handshake (both the fill side and the processing side):
//   the controller raises a one-cycle kick pulse when it hands over a bank;
//   the peer answers with a one-cycle done pulse when it has finished with
//   that bank. There is no back-pressure. A done that does not match a bank
//   in flight is a protocol error: it sets the sticky err flag and is
//   otherwise ignored.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse that begins a run (ignored unless idle)
//   fill_kick  one-hot per-bank fill kick pulse
//   fill_done  per-bank fill done pulse
//   hs_angle   angle of the line being filled
//   pr_kick    one-cycle pulse: processing may start on pr_bank
//   pr_bank    bank handed to processing, stable until pr_done
//   pr_angle   angle held in pr_bank
//   pr_done    one-cycle pulse: processing has finished with pr_bank
//   busy       high while a run is active
//   done       one-cycle pulse after the last line is processed
//   err        sticky protocol error, cleared by start or reset
//   stall_cnt  (only with NABP_SWAP_STALL_COUNT_EN) saturating count of run
//              cycles in which processing waits for a filled bank
//
// Optional feature macro: NABP_SWAP_STALL_COUNT_EN
// -----------------------------------------------------------------------------
module nabp_filtered_ram_swap_ctrl #(
  parameter int NUM_ANGLES = 180,
  parameter int ANGLE_W    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic [1:0]         fill_kick,
  input  logic [1:0]         fill_done,
  output logic [ANGLE_W-1:0] hs_angle,
  output logic               pr_kick,
  output logic               pr_bank,
  output logic [ANGLE_W-1:0] pr_angle,
  input  logic               pr_done,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef NABP_SWAP_STALL_COUNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2,
    B_PROC    = 2'd3
  } bank_st_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } run_st_t;

  // Counters carry one extra bit so NUM_ANGLES = 2^ANGLE_W does not wrap.
  localparam logic [ANGLE_W:0] NUM_C = (ANGLE_W+1)'(NUM_ANGLES);

  run_st_t            run_st;
  bank_st_t           bank_st    [2];
  logic [ANGLE_W-1:0] bank_angle [2];
  logic               fill_ptr;
  logic               pr_ptr;
  logic [ANGLE_W:0]   fill_cnt;
  logic [ANGLE_W:0]   pr_cnt;

  // Done-event qualification.
  logic fd_any;
  logic fd_bank;
  logic fd_ok;
  logic fd_err;
  logic pd_ok;
  logic pd_err;

  // Bookkeeping as it stands once this cycle's done pulses are applied. Kick
  // decisions look at this view so a bank freed or filled at edge t can be
  // re-kicked or handed to processing at t+1.
  bank_st_t         st_a [2];
  logic             fill_ptr_a;
  logic             pr_ptr_a;
  logic [ANGLE_W:0] fill_cnt_a;
  logic [ANGLE_W:0] pr_cnt_a;
  logic             any_filling_a;
  logic             any_proc_a;
  logic             fill_go;
  logic             pr_go;
  logic             last_line;

  always_comb begin
    fd_any  = fill_done[0] ^ fill_done[1];
    fd_bank = fill_done[1];
    fd_ok   = (run_st == S_RUN) && fd_any && (bank_st[fd_bank] == B_FILLING);
    // Both bits at once, or a single bit on a bank that is not filling.
    fd_err  = (fill_done != 2'b00) && !fd_ok;
    pd_ok   = (run_st == S_RUN) && pr_done && (bank_st[pr_bank] == B_PROC);
    pd_err  = pr_done && !pd_ok;

    st_a[0]    = bank_st[0];
    st_a[1]    = bank_st[1];
    fill_ptr_a = fill_ptr;
    pr_ptr_a   = pr_ptr;
    fill_cnt_a = fill_cnt;
    pr_cnt_a   = pr_cnt;
    if (fd_ok) begin
      st_a[fd_bank] = B_FULL;
      fill_ptr_a    = ~fill_ptr;
      fill_cnt_a    = fill_cnt + 1'b1;
    end
    if (pd_ok) begin
      st_a[pr_bank] = B_EMPTY;
      pr_ptr_a      = ~pr_ptr;
      pr_cnt_a      = pr_cnt + 1'b1;
    end

    any_filling_a = (st_a[0] == B_FILLING) || (st_a[1] == B_FILLING);
    any_proc_a    = (st_a[0] == B_PROC) || (st_a[1] == B_PROC);
    fill_go       = (fill_cnt_a < NUM_C) && (st_a[fill_ptr_a] == B_EMPTY) &&
                    !any_filling_a;
    pr_go         = !any_proc_a && (st_a[pr_ptr_a] == B_FULL);
    last_line     = (pr_cnt_a == NUM_C);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_st        <= S_IDLE;
      bank_st[0]    <= B_EMPTY;
      bank_st[1]    <= B_EMPTY;
      bank_angle[0] <= '0;
      bank_angle[1] <= '0;
      fill_ptr      <= 1'b0;
      pr_ptr        <= 1'b0;
      fill_cnt      <= '0;
      pr_cnt        <= '0;
      fill_kick     <= 2'b00;
      hs_angle      <= '0;
      pr_kick       <= 1'b0;
      pr_bank       <= 1'b0;
      pr_angle      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      fill_kick <= 2'b00;
      pr_kick   <= 1'b0;
      done      <= 1'b0;
      if (fd_err || pd_err) begin
        err <= 1'b1;
      end

      case (run_st)
        S_IDLE: begin
          if (start) begin
            // Clear the run and kick bank 0 straight away: both banks are
            // empty and at least one line is always requested.
            run_st        <= S_RUN;
            busy          <= 1'b1;
            err           <= 1'b0;
            bank_st[0]    <= B_FILLING;
            bank_st[1]    <= B_EMPTY;
            bank_angle[0] <= '0;
            fill_ptr      <= 1'b0;
            pr_ptr        <= 1'b0;
            fill_cnt      <= '0;
            pr_cnt        <= '0;
            fill_kick     <= 2'b01;
            hs_angle      <= '0;
          end
        end

        S_RUN: begin
          bank_st[0] <= st_a[0];
          bank_st[1] <= st_a[1];
          fill_ptr   <= fill_ptr_a;
          pr_ptr     <= pr_ptr_a;
          fill_cnt   <= fill_cnt_a;
          pr_cnt     <= pr_cnt_a;
          if (last_line) begin
            run_st <= S_FINISH;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            // fill_go targets an EMPTY bank and pr_go a FULL one, so the two
            // updates below never touch the same bank.
            if (fill_go) begin
              fill_kick[fill_ptr_a]  <= 1'b1;
              bank_st[fill_ptr_a]    <= B_FILLING;
              bank_angle[fill_ptr_a] <= fill_cnt_a[ANGLE_W-1:0];
              hs_angle               <= fill_cnt_a[ANGLE_W-1:0];
            end
            if (pr_go) begin
              pr_kick           <= 1'b1;
              pr_bank           <= pr_ptr_a;
              pr_angle          <= bank_angle[pr_ptr_a];
              bank_st[pr_ptr_a] <= B_PROC;
            end
          end
        end

        // One cycle of guard so a start arriving with the done pulse's
        // neighbour cycle is not taken.
        S_FINISH: run_st <= S_IDLE;

        default: run_st <= S_IDLE;
      endcase
    end
  end

`ifdef NABP_SWAP_STALL_COUNT_EN
  // Processing is starved when a run is active, lines remain, and neither
  // bank is being processed (registered view of the current cycle).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if ((run_st == S_IDLE) && start) begin
      stall_cnt <= '0;
    end else if ((run_st == S_RUN) && (bank_st[0] != B_PROC) &&
                 (bank_st[1] != B_PROC) && (pr_cnt < NUM_C) &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nabp_filtered_ram_swap_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for nabp_filtered_ram_swap_ctrl. Two instances: NUM_ANGLES=4 and
// NUM_ANGLES=1, selected by sel. A line-level reference model tracks counts of
// fills issued/completed and lines kicked/processed, and predicts every kick,
// angle, busy, done and err value cycle by cycle.
// -----------------------------------------------------------------------------
module tb_nabp_filtered_ram_swap_ctrl;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared drive, routed to the selected DUT ----------------
  logic       sel;
  logic       start_d;
  logic [1:0] fill_done_d;
  logic       pr_done_d;

  logic          start4, start1, pd4, pd1;
  logic [1:0]    fd4, fd1;
  logic [1:0]    fk4, fk1;
  logic [AW-1:0] hs4, hs1, pa4, pa1;
  logic          pk4, pk1, pb4, pb1, busy4, busy1, done4, done1, err4, err1;

  assign start4 = start_d & ~sel;
  assign start1 = start_d & sel;
  assign fd4    = sel ? 2'b00 : fill_done_d;
  assign fd1    = sel ? fill_done_d : 2'b00;
  assign pd4    = pr_done_d & ~sel;
  assign pd1    = pr_done_d & sel;

`ifdef NABP_SWAP_STALL_COUNT_EN
  logic [15:0] st4, st1, obs_stall;
  assign obs_stall = sel ? st1 : st4;
`endif

  nabp_filtered_ram_swap_ctrl #(.NUM_ANGLES(4), .ANGLE_W(AW)) u4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .fill_kick(fk4),
    .fill_done(fd4), .hs_angle(hs4), .pr_kick(pk4), .pr_bank(pb4),
    .pr_angle(pa4), .pr_done(pd4), .busy(busy4), .done(done4), .err(err4)
`ifdef NABP_SWAP_STALL_COUNT_EN
    , .stall_cnt(st4)
`endif
  );

  nabp_filtered_ram_swap_ctrl #(.NUM_ANGLES(1), .ANGLE_W(AW)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .fill_kick(fk1),
    .fill_done(fd1), .hs_angle(hs1), .pr_kick(pk1), .pr_bank(pb1),
    .pr_angle(pa1), .pr_done(pd1), .busy(busy1), .done(done1), .err(err1)
`ifdef NABP_SWAP_STALL_COUNT_EN
    , .stall_cnt(st1)
`endif
  );

  logic [1:0]    obs_fk;
  logic [AW-1:0] obs_hs, obs_pa;
  logic          obs_pk, obs_pb, obs_busy, obs_done, obs_err;
  assign obs_fk   = sel ? fk1 : fk4;
  assign obs_hs   = sel ? hs1 : hs4;
  assign obs_pk   = sel ? pk1 : pk4;
  assign obs_pb   = sel ? pb1 : pb4;
  assign obs_pa   = sel ? pa1 : pa4;
  assign obs_busy = sel ? busy1 : busy4;
  assign obs_done = sel ? done1 : done4;
  assign obs_err  = sel ? err1 : err4;

  // ---------------- reference model state ----------------
  int n_ang;
  int m_run, m_fin;
  int m_fi, m_fd, m_pi, m_pd;       // fills issued/done, lines kicked/done
  int m_fill_fl, m_pr_fl;           // one fill / one process in flight
  int m_err, exp_stall;
  int ft, fb, pt;                   // responder timers and filling bank
  int f_lo, f_hi, p_lo, p_hi;       // responder latency ranges
  int done_seen, kicks_b0, kicks_b1, pr_kicks, done_pulses;
  logic [AW-1:0] exp_q[$];          // filled angles awaiting processing

  // ---------------- scoreboard ----------------
  int total;
  int bad;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- one clock of model + checks + responder ----------------
  task automatic step();
    logic          l_start, l_pd, e_pk, e_done, e_pb;
    logic [1:0]    l_fd, e_fk;
    logic [AW-1:0] e_hs, e_pa;
    int            fill_bank;
    l_start = start_d;
    l_fd    = fill_done_d;
    l_pd    = pr_done_d;
    @(negedge clk);
    if (m_run != 0 && m_pr_fl == 0 && m_pd < n_ang) exp_stall++;
    e_fk = 2'b00; e_pk = 1'b0; e_done = 1'b0;
    e_hs = '0; e_pa = '0; e_pb = 1'b0;
    if (l_start && m_run == 0 && m_fin == 0) begin
      m_run = 1; m_fi = 1; m_fd = 0; m_pi = 0; m_pd = 0;
      m_fill_fl = 1; m_pr_fl = 0; m_err = 0; exp_stall = 0;
      exp_q.delete();
      e_fk = 2'b01; fb = 0; pt = 0;
      ft = $urandom_range(f_hi, f_lo);
      done_seen = 0; kicks_b0 = 0; kicks_b1 = 0; pr_kicks = 0; done_pulses = 0;
    end else begin
      m_fin = 0;
      if (l_fd != 2'b00) begin
        fill_bank = (m_fi - 1) % 2;
        if (m_run != 0 && m_fill_fl != 0 && l_fd == (2'b01 << fill_bank)) begin
          m_fd++;
          m_fill_fl = 0;
          exp_q.push_back(AW'(m_fi - 1));
        end else begin
          m_err = 1;
        end
      end
      if (l_pd) begin
        if (m_run != 0 && m_pr_fl != 0) begin
          m_pd++;
          m_pr_fl = 0;
        end else begin
          m_err = 1;
        end
      end
      if (m_run != 0) begin
        if (m_pd == n_ang) begin
          e_done = 1'b1; m_run = 0; m_fin = 1;
        end else begin
          // Line m_fi goes to bank m_fi%2, which is free once line m_fi-2
          // has been processed.
          if (m_fill_fl == 0 && m_fi < n_ang && (m_fi - m_pd) < 2) begin
            e_fk = 2'b01 << (m_fi % 2);
            e_hs = AW'(m_fi);
            fb = m_fi % 2;
            m_fi++;
            m_fill_fl = 1;
            ft = $urandom_range(f_hi, f_lo);
          end
          if (m_pr_fl == 0 && m_pi < m_fd) begin
            e_pk = 1'b1;
            e_pb = m_pi[0];
            e_pa = exp_q.pop_front();
            m_pi++;
            m_pr_fl = 1;
            pt = $urandom_range(p_hi, p_lo);
          end
        end
      end
    end

    check("fill_kick", 32'(obs_fk), 32'(e_fk));
    check("pr_kick", 32'(obs_pk), 32'(e_pk));
    check("done", 32'(obs_done), 32'(e_done));
    check("busy", 32'(obs_busy), 32'(m_run != 0));
    check("err", 32'(obs_err), 32'(m_err != 0));
    if (e_fk != 2'b00) check("hs_angle", 32'(obs_hs), 32'(e_hs));
    if (e_pk) begin
      check("pr_bank", 32'(obs_pb), 32'(e_pb));
      check("pr_angle", 32'(obs_pa), 32'(e_pa));
    end
    if (obs_fk[0]) kicks_b0++;
    if (obs_fk[1]) kicks_b1++;
    if (obs_pk) pr_kicks++;
    if (obs_done) done_pulses++;
    if (e_done) done_seen = 1;

    // responder: done pulses the programmed number of cycles after a kick
    start_d = 1'b0;
    fill_done_d = 2'b00;
    if (ft > 0) begin
      ft--;
      if (ft == 0) fill_done_d = 2'b01 << fb;
    end
    pr_done_d = 1'b0;
    if (pt > 0) begin
      pt--;
      if (pt == 0) pr_done_d = 1'b1;
    end
  endtask

  task automatic set_lat(input int flo, input int fhi, input int plo, input int phi);
    f_lo = flo; f_hi = fhi; p_lo = plo; p_hi = phi;
  endtask

  task automatic do_start();
    start_d = 1'b1;
    step();
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_seen == 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_finished"}, 32'(done_seen), 32'd1);
  endtask

  task automatic check_run_totals(input string tag);
    check({tag, "_kicks_b0"}, 32'(kicks_b0), 32'((n_ang + 1) / 2));
    check({tag, "_kicks_b1"}, 32'(kicks_b1), 32'(n_ang / 2));
    check({tag, "_pr_kicks"}, 32'(pr_kicks), 32'(n_ang));
    check({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
`ifdef NABP_SWAP_STALL_COUNT_EN
    check({tag, "_stall_cnt"}, 32'(obs_stall), 32'(exp_stall));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    total = 0; bad = 0;
    sel = 1'b0; n_ang = 4;
    start_d = 1'b0; fill_done_d = 2'b00; pr_done_d = 1'b0;
    m_run = 0; m_fin = 0; m_fi = 0; m_fd = 0; m_pi = 0; m_pd = 0;
    m_fill_fl = 0; m_pr_fl = 0; m_err = 0; exp_stall = 0;
    ft = 0; fb = 0; pt = 0; done_seen = 0;
    kicks_b0 = 0; kicks_b1 = 0; pr_kicks = 0; done_pulses = 0;
    set_lat(10, 10, 20, 20);

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_n4", 32'({fk4, hs4, pk4, pb4, pa4, busy4, done4, err4}), 32'd0);
    check("reset_outs_n1", 32'({fk1, hs1, pk1, pb1, pa1, busy1, done1, err1}), 32'd0);
`ifdef NABP_SWAP_STALL_COUNT_EN
    check("reset_stall", 32'(st4), 32'd0);
`endif
    reset_n = 1'b1;
    idle(2);

    // Nominal: fill 10, process 20.
    do_start();
    run_to_done("nominal", 2000);
    check_run_totals("nominal");
    idle(3);

    // Slow fill, fast processing: processing starves between lines.
    set_lat(50, 50, 1, 1);
    do_start();
    run_to_done("slow_fill", 2000);
    check_run_totals("slow_fill");
    idle(2);

    // Equal latencies: fill_done[1] coincides with pr_done on bank 0.
    set_lat(6, 6, 6, 6);
    do_start();
    run_to_done("same_cycle", 2000);
    check_run_totals("same_cycle");
    check("same_cycle_err", 32'(obs_err), 32'd0);
    idle(2);

    // Randomised latencies, with a start pulse that must be ignored mid-run.
    set_lat(1, 15, 1, 15);
    for (int r = 0; r < 3; r++) begin
      do_start();
      idle(4);
      start_d = 1'b1;
      run_to_done("random", 2000);
      check_run_totals("random");
      idle($urandom_range(4, 2));
    end

    // Spurious done pulses while idle.
    pr_done_d = 1'b1;
    step();
    check("idle_pr_done_err", 32'(obs_err), 32'd1);
    fill_done_d = 2'b10;
    idle(2);

    // Start clears err; then fill_done[1] while bank 1 is still empty.
    set_lat(8, 8, 5, 5);
    do_start();
    fill_done_d = fill_done_d | 2'b10;
    run_to_done("spurious_fd1", 2000);
    check_run_totals("spurious_fd1");
    check("spurious_fd1_err", 32'(obs_err), 32'd1);
    idle(2);

    // Both fill_done bits at once mid-run.
    do_start();
    idle(2);
    fill_done_d = fill_done_d | 2'b11;
    run_to_done("double_fd", 2000);
    check_run_totals("double_fd");
    idle(2);

    // Reset while bank 0 is processing.
    set_lat(4, 4, 30, 30);
    do_start();
    for (int i = 0; i < 100 && m_pr_fl == 0; i++) step();
    idle(3);
    check("pre_reset_proc_bank0", 32'(obs_pb), 32'd0);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outs", 32'({fk4, hs4, pk4, pb4, pa4, busy4, done4, err4}), 32'd0);
`ifdef NABP_SWAP_STALL_COUNT_EN
    check("async_reset_stall", 32'(st4), 32'd0);
`endif
    m_run = 0; m_fin = 0; m_fill_fl = 0; m_pr_fl = 0; m_err = 0; exp_stall = 0;
    ft = 0; pt = 0; exp_q.delete();
    start_d = 1'b0; fill_done_d = 2'b00; pr_done_d = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    check("post_reset_no_done", 32'(done_pulses), 32'd0);
    set_lat(3, 9, 2, 12);
    do_start();
    run_to_done("after_reset", 2000);
    check_run_totals("after_reset");
    idle(2);

    // Single-line run on the NUM_ANGLES=1 instance.
    sel = 1'b1; n_ang = 1;
    set_lat(3, 3, 2, 2);
    idle(2);
    do_start();
    run_to_done("single", 500);
    check_run_totals("single");
    check("single_bank1_unused", 32'(kicks_b1), 32'd0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
